// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with a valid/ready handshake and a one-entry skid buffer.
// in_ready and out_valid decode straight from the state flop, so backpressure stays registered.
//
// state | meaning
// EMPTY | nothing held; out_valid=0, in_ready=1
// BUSY  | main_q valid, skid empty; out_valid=1, in_ready=1
// FULL  | main_q and skid_q valid; out_valid=1, in_ready=0
module pipe_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;
    logic             in_accept;
    logic             out_accept;

    assign in_ready   = (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = main_q;
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Only validity is dropped; any word offered this cycle is discarded.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_accept) begin
                        state_d      = BUSY;
                        load_main_in = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_accept && out_accept) begin
                        load_main_in = 1'b1;
                    end else if (in_accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_accept) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_accept) begin
                        state_d        = BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    // Saturating debug counter; flush deliberately leaves it alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: streaming, backpressure, flush, reset and counter saturation.
module tb_pipe_skid_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    pipe_skid_stage #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'd0);
        check("rst_stall", {16'd0, stall_count}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1111_1111;
        tick();
        check("str1_valid", {31'd0, out_valid}, 32'd1);
        check("str1_data", out_data, 32'h1111_1111);
        check("str1_ready", {31'd0, in_ready}, 32'd1);
        in_data = 32'h2222_2222;
        tick();
        check("str2_data", out_data, 32'h2222_2222);
        check("str2_ready", {31'd0, in_ready}, 32'd1);
        in_data = 32'h3333_3333;
        tick();
        check("str3_data", out_data, 32'h3333_3333);
        check("str3_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("str_drain_valid", {31'd0, out_valid}, 32'd0);
        check("str_stall", {16'd0, stall_count}, 32'd0);

        // backpressure
        in_valid  = 1'b1;
        in_data   = 32'hA0;
        out_ready = 1'b1;
        tick();
        check("bp_a0", out_data, 32'hA0);
        in_data   = 32'hA1;
        out_ready = 1'b0;
        tick();
        in_data = 32'hA2;
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_full_data", out_data, 32'hA0);
        check("bp_stall1", {16'd0, stall_count}, 32'd1);
        repeat (4) tick();
        check("bp_stall5", {16'd0, stall_count}, 32'd5);
        check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_data", out_data, 32'hA0);
        out_ready = 1'b1;
        tick();
        check("bp_a1", out_data, 32'hA1);
        check("bp_a1_ready", {31'd0, in_ready}, 32'd1);
        check("bp_a1_stall", {16'd0, stall_count}, 32'd5);
        tick();
        check("bp_a2", out_data, 32'hA2);
        check("bp_a2_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);

        // flush while FULL
        in_valid  = 1'b1;
        in_data   = 32'hB0;
        out_ready = 1'b0;
        tick();
        in_data = 32'hB1;
        tick();
        check("fl_full_ready", {31'd0, in_ready}, 32'd0);
        check("fl_pre_stall", {16'd0, stall_count}, 32'd6);
        flush   = 1'b1;
        in_data = 32'hDEAD;
        tick();
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        check("fl_stall", {16'd0, stall_count}, 32'd7);
        check("fl_data_kept", out_data, 32'hB0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_no_dead", {31'd0, out_valid}, 32'd0);

        // simultaneous accept in BUSY
        in_valid = 1'b1;
        in_data  = 32'h5;
        tick();
        check("sim_5", out_data, 32'h5);
        in_data = 32'h6;
        tick();
        check("sim_6", out_data, 32'h6);
        check("sim_ready", {31'd0, in_ready}, 32'd1);
        check("sim_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("sim_drain", {31'd0, out_valid}, 32'd0);

        // asynchronous reset while FULL
        in_valid  = 1'b1;
        in_data   = 32'hC0;
        out_ready = 1'b0;
        tick();
        in_data = 32'hC1;
        tick();
        check("rf_full_ready", {31'd0, in_ready}, 32'd0);
        check("rf_stall", {16'd0, stall_count}, 32'd8);
        #2;
        reset_n = 1'b0;
        #1;
        check("rf_out_valid", {31'd0, out_valid}, 32'd0);
        check("rf_in_ready", {31'd0, in_ready}, 32'd1);
        check("rf_out_data", out_data, 32'd0);
        check("rf_stall0", {16'd0, stall_count}, 32'd0);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("rf_after_valid", {31'd0, out_valid}, 32'd0);

        // saturation
        in_valid = 1'b1;
        in_data  = 32'h77;
        tick();
        in_valid = 1'b0;
        check("sat_start", {16'd0, stall_count}, 32'd0);
        repeat (65534) tick();
        check("sat_fffe", {16'd0, stall_count}, 32'h0000_FFFE);
        tick();
        check("sat_ffff", {16'd0, stall_count}, 32'h0000_FFFF);
        repeat (10) tick();
        check("sat_nowrap", {16'd0, stall_count}, 32'h0000_FFFF);
        check("sat_data", out_data, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parameterised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It sits between two datapath stages, the producer upstream and the consumer downstream. It gives full one-word-per-cycle throughput while keeping `in_ready` driven straight from a flop, so backpressure never forms a long combinational path. It also supports a synchronous pipeline flush and counts downstream stall cycles for debug.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `clock`  in  1: rising-edge clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: synchronous flush; discards all held words.
- `in_valid`  in  1: producer presents a word.
- `in_data`  in  WIDTH: producer word.
- `in_ready`  out  1: stage can accept a word this cycle.
- `out_valid`  out  1: stage presents a word.
- `out_data`  out  WIDTH: presented word.
- `out_ready`  in  1: consumer accepts the presented word.
- `stall_count`  out  16: saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Transfer rules:
  - Input accept is `in_valid && in_ready`.
  - Output accept is `out_valid && out_ready`.
  - Words leave in arrival order. None is dropped or duplicated, except on flush.
- Storage:
  - Main register `main_q` drives `out_data`.
  - Skid register `skid_q` holds one overflow word.
- States:
  - EMPTY: nothing held. `out_valid=0`, `in_ready=1`.
  - BUSY: `main_q` valid, skid empty. `out_valid=1`, `in_ready=1`.
  - FULL: both registers valid. `out_valid=1`, `in_ready=0`.
- Transitions when `flush=0`:
  - EMPTY, input accept -> BUSY, `main_q<=in_data`.
  - EMPTY, no input accept -> EMPTY.
  - BUSY, input and output accept -> BUSY, `main_q<=in_data`.
  - BUSY, input accept, no output accept -> FULL, `skid_q<=in_data`.
  - BUSY, output accept, no input accept -> EMPTY.
  - BUSY, neither -> BUSY (hold).
  - FULL, output accept -> BUSY, `main_q<=skid_q`.
  - FULL, no output accept -> FULL (hold).
- Flush:
  - `flush=1` forces the state to EMPTY at the next edge, regardless of state or handshakes.
  - A word offered by the producer in the flush cycle is discarded, even if `in_ready=1`.
  - Data registers keep their contents. Only validity is cleared.
- `stall_count`:
  - Increments by 1 on each edge where `out_valid && !out_ready` held in the preceding cycle.
  - Saturates at 16'hFFFF.
  - Cleared only by reset. Flush does not clear it.
  - A flush cycle with `out_valid && !out_ready` still counts.
- `out_data` is meaningful only while `out_valid=1`. It otherwise holds its last value.

## Timing
- Reset values, applied asynchronously while `reset_n=0`:
  - State EMPTY, so `out_valid=0` and `in_ready=1`.
  - `main_q`, `skid_q` and `out_data` all 0.
  - `stall_count=0`.
- Deassertion of `reset_n` is synchronised externally. The first accept can occur on the first edge after release.
- `in_ready` and `out_valid` are decoded directly from the state register. There is no combinational path from `out_ready` or `in_valid` to `in_ready`.
- `out_data` comes directly from `main_q`.
- Latency: a word accepted at edge N appears with `out_valid=1` after edge N, i.e. one cycle.
- Throughput is 1 word/cycle while `out_ready=1`.
- Backpressure: when `out_ready` drops while the producer streams, exactly one extra word is absorbed (BUSY -> FULL). `in_ready` falls one cycle after `out_ready` falls.
- `in_ready` rises one cycle after the first output accept in FULL.
- Reset mid-transfer: held words are lost. No output accept is reported during or after the reset.

## Test plan
- Reset check: assert `reset_n=0` mid-stream with FULL state -> immediately `out_valid=0`, `in_ready=1`, `out_data=0`, `stall_count=0`.
- Streaming: `out_ready=1`, push 0x11111111, 0x22222222 and 0x33333333 on consecutive cycles -> each appears on `out_data` one cycle later, in order. `in_ready` stays 1 and `stall_count` stays 0.
- Backpressure: push 0xA0, 0xA1 and 0xA2 back-to-back, with `out_ready=0` from the second cycle:
  - State reaches FULL holding 0xA0 and 0xA1, and `in_ready=0`. 0xA2 is not accepted and is re-offered.
  - Hold for 5 cycles -> `stall_count=5`.
  - Raise `out_ready` -> 0xA0, 0xA1 and 0xA2 are delivered in order.
- Flush: in FULL, assert `flush` for one cycle while offering 0xDEAD -> next cycle `out_valid=0` and `in_ready=1`, and 0xDEAD never appears. `stall_count` does not reset.
- Simultaneous accept in BUSY: hold 0x5, offer 0x6 with `out_ready=1` -> 0x5 is consumed, 0x6 is in `main_q`, state stays BUSY with no skid use.
- Saturation: keep `out_valid=1`, `out_ready=0` for 70000 cycles -> `stall_count=16'hFFFF` and it does not wrap.
